// File: rtl/sobel_out_packer.sv
// Packs the Sobel edge-pixel stream four-per-word into 32-bit stream beats, buffered by a
// small FIFO. The upstream source cannot be stalled, so words that do not fit are dropped.
module sobel_out_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 21
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [7:0]       pixel_in,
  input  logic             valid_in,
  input  logic             done_in,
  output logic [31:0]      m_tdata,
  output logic [3:0]       m_tkeep,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             overflow,
  output logic [CNT_W-1:0] word_count,
  output logic             frame_done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StRun, StFlush, StDrain} state_e;

  state_e            r_state, w_state_d;
  logic [31:0]       r_asm, w_asm_d;
  logic [1:0]        r_idx, w_idx_d;
  logic [31:0]       r_hold, w_hold_d;
  logic              r_hold_vld, w_hold_vld_d;
  logic              r_overflow, w_overflow_d;
  logic              r_frame_done, w_frame_done_d;
  logic [CNT_W-1:0]  r_word_count, w_word_count_d;
  logic [CNT_W-1:0]  r_run_cnt, w_run_cnt_d, w_run_inc;
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]     r_count;
  logic [36:0]       r_mem [FIFO_DEPTH];

  logic              w_push, w_push_last, w_pop, w_space, w_tvalid;
  logic [3:0]        w_push_keep, w_keep_part;
  logic [31:0]       w_push_data;
  logic [36:0]       w_head;

  // Head entry is a flop read through the read pointer, so it holds steady under backpressure.
  assign w_head   = r_mem[r_rd_ptr];
  assign w_tvalid = (r_count != '0);
  assign w_pop    = w_tvalid & m_tready;
  assign w_space  = (r_count != FullCount) | w_pop;
  assign w_run_inc = (r_run_cnt == '1) ? r_run_cnt : r_run_cnt + 1'b1;
  assign w_keep_part = {1'b0, (r_idx == 2'd3), r_idx[1], 1'b1};

  assign m_tvalid = w_tvalid;
  assign {m_tlast, m_tkeep, m_tdata} = w_tvalid ? w_head : '0;
  assign overflow   = r_overflow;
  assign word_count = r_word_count;
  assign frame_done = r_frame_done;

  always_comb begin
    w_state_d      = r_state;
    w_asm_d        = r_asm;
    w_idx_d        = r_idx;
    w_hold_d       = r_hold;
    w_hold_vld_d   = r_hold_vld;
    w_overflow_d   = r_overflow;
    w_frame_done_d = 1'b0;
    w_word_count_d = r_word_count;
    w_run_cnt_d    = w_pop ? w_run_inc : r_run_cnt;
    w_push         = 1'b0;
    w_push_data    = '0;
    w_push_keep    = '0;
    w_push_last    = 1'b0;
    unique case (r_state)
      StRun: begin
        if (valid_in) begin
          if (r_hold_vld) begin
            if (w_space) begin
              w_push      = 1'b1;
              w_push_data = r_hold;
              w_push_keep = 4'hF;
            end else begin
              w_overflow_d = 1'b1;
            end
            w_hold_vld_d = 1'b0;
          end
          if (r_idx == 2'd3) begin
            w_hold_d     = {pixel_in, r_asm[23:0]};
            w_hold_vld_d = 1'b1;
            w_asm_d      = '0;
          end else begin
            w_asm_d[{r_idx, 3'b000} +: 8] = pixel_in;
          end
          w_idx_d = r_idx + 2'd1;
        end
        if (done_in) begin
          w_state_d = StFlush;
          // Empty frame: nothing will ever carry tlast, so finish the frame right away.
          if (!w_hold_vld_d && (w_idx_d == 2'd0)) begin
            w_frame_done_d = 1'b1;
            w_word_count_d = w_run_cnt_d;
            w_run_cnt_d    = '0;
          end
        end
      end
      StFlush: begin
        if (valid_in) w_overflow_d = 1'b1;
        if (r_hold_vld) begin
          if (w_space) begin
            w_push       = 1'b1;
            w_push_data  = r_hold;
            w_push_keep  = 4'hF;
            w_push_last  = (r_idx == 2'd0);
            w_hold_vld_d = 1'b0;
            if (r_idx == 2'd0) w_state_d = StDrain;
          end
        end else if (r_idx != 2'd0) begin
          if (w_space) begin
            w_push      = 1'b1;
            w_push_data = r_asm;
            w_push_keep = w_keep_part;
            w_push_last = 1'b1;
            w_asm_d     = '0;
            w_idx_d     = 2'd0;
            w_state_d   = StDrain;
          end
        end else begin
          w_state_d = StRun;
        end
      end
      StDrain: begin
        if (valid_in) w_overflow_d = 1'b1;
        if (w_pop && w_head[36]) begin
          w_frame_done_d = 1'b1;
          w_word_count_d = w_run_inc;
          w_run_cnt_d    = '0;
          w_state_d      = StRun;
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_push_last, w_push_keep, w_push_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StRun;
      r_asm        <= '0;
      r_idx        <= '0;
      r_hold       <= '0;
      r_hold_vld   <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_word_count <= '0;
      r_run_cnt    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else if (clear) begin
      r_state      <= StRun;
      r_asm        <= '0;
      r_idx        <= '0;
      r_hold       <= '0;
      r_hold_vld   <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_word_count <= '0;
      r_run_cnt    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_d;
      r_asm        <= w_asm_d;
      r_idx        <= w_idx_d;
      r_hold       <= w_hold_d;
      r_hold_vld   <= w_hold_vld_d;
      r_overflow   <= w_overflow_d;
      r_frame_done <= w_frame_done_d;
      r_word_count <= w_word_count_d;
      r_run_cnt    <= w_run_cnt_d;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: doc/sobel_out_packer.md
Name: sobel_out_packer

Overview:
- Sits directly downstream of the Sobel processing top.
- Consumes its 8-bit edge pixel stream (pixel/valid) and the end-of-image pulse, and packs pixels four-per-word into 32-bit beats.
- Beats go through a small FIFO and out a stream master (valid/ready, keep, last) towards the frame-writer DMA.
- The upstream core has no backpressure, so words that cannot be buffered are dropped and flagged.

Parameters:
- FIFO_DEPTH, 8, output FIFO depth in 32-bit words; power of two, at least 2.
- CNT_W, 21, width of the per-frame beat counter; covers 2048x2048 pixels / 4, plus the partial word.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous soft clear, one-cycle pulse.
- pixel_in  in  8  edge pixel from the Sobel stage.
- valid_in  in  1  pixel_in qualifier.
- done_in  in  1  end-of-image pulse from the Sobel stage; may coincide with the last valid_in.
- m_tdata  out  32  packed word; first pixel of the word in bits [7:0].
- m_tkeep  out  4  byte enables, one per pixel lane.
- m_tlast  out  1  last beat of the frame.
- m_tvalid  out  1  beat valid.
- m_tready  in  1  downstream accept.
- overflow  out  1  sticky: at least one word dropped.
- word_count  out  CNT_W  beats accepted in the last completed frame.
- frame_done  out  1  one-cycle pulse when the frame is fully delivered.

Behaviour:
- Reset (reset_n low, asynchronous) and clear (synchronous, highest priority) both put every output at 0.
- They also empty the FIFO, assembly register and hold register, and return state to RUN.
- clear may drop m_tvalid mid-beat; this is accepted.
- Assembly: 2-bit lane index idx. Each valid_in writes pixel_in to lane idx, then idx increments.
- When idx wraps 3->0, the full word (keep 4'hF) moves to the hold register on the next edge.
- Hold rule: the full word is held, not pushed, so tlast can be attached later. It is pushed to the FIFO (tlast=0) in the cycle the next valid_in arrives.
- If the FIFO is full at push time, the word is discarded and overflow is set.
- valid_in arriving while in FLUSH or DRAIN is discarded and sets overflow.
- FIFO output: registered head. While m_tvalid=1 and m_tready=0, m_tdata, m_tkeep and m_tlast are stable.
- Transfer occurs on m_tvalid & m_tready.
- Latency: a word is pushed at cycle P; m_tvalid asserts at P+1 if the FIFO was empty.
- FIFO full and FIFO empty are mutually exclusive.
- A simultaneous push and pop when full is legal: the pop frees the slot in the same cycle, with no drop.

State machine:
- RUN: normal packing.
- On done_in (after including any coincident pixel), go to FLUSH.
- FLUSH: pushes the final words one per cycle, stalling (never dropping) while the FIFO is full. Order:
  - First, the hold word (if valid), with tlast=1 only when the assembly register is empty.
  - Second, the partial word (if idx>0), with keep = (1<<idx)-1, unused lanes 0, tlast=1.
  - If nothing is pending (empty frame), go straight from FLUSH back to RUN, pulsing frame_done in the cycle after done_in.
  - Otherwise go to DRAIN.
- DRAIN: waits for the tlast beat to be accepted.
- That cycle+1: frame_done=1, word_count latches the running beat count, the running count clears, and state returns to RUN.
- Running counter: increments per accepted beat and saturates at all-ones.
- done_in while in FLUSH or DRAIN is ignored.
- overflow clears only on reset or clear.

Test Plan:
- Pixels 0x01..0x08 on consecutive cycles, done_in with the 8th, m_tready=1 -> beats 0x04030201/keep F/last 0, then 0x08070605/keep F/last 1; frame_done pulses once; word_count=2; overflow=0.
- Pixels 0x10..0x15, done_in one cycle after the last -> beats 0x13121110/keep F, then 0x00001514/keep 0x3/last 1; word_count=2.
- m_tready=0, stream 4*(FIFO_DEPTH+2) pixels -> overflow=1; head word 0x03020100 stays stable throughout the stall. Release m_tready -> exactly FIFO_DEPTH words in order. Then clear -> overflow=0, m_tvalid=0.
- done_in with no prior pixels -> no beat issued; frame_done pulses the cycle after done_in; word_count=0.
- 3 pixels, then reset_n low for 2 cycles -> all outputs 0. Then 4 pixels 0xAA,0xBB,0xCC,0xDD plus done_in -> single beat 0xDDCCBBAA/keep F/last 1.
- One pixel per cycle for 64 pixels, m_tready toggling every cycle -> 16 beats in order, overflow=0, word_count=16.
